game_state_ctl: RTL and testbench

//  Match-level sequencer directly downstream of the ball/score controller. Consumes

---
 rtl/game_state_ctl.sv | 169 ++++++++++++++++
 tb/tb_game_state_ctl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctl.sv
// ---------------------------------------------------------------------------
// game_state_ctl
//
// Match-level sequencer that sits directly after the ball/score controller.
// It watches both player scores for goals and drives the match through its
// states: IDLE -> START -> PLAY <-> PAUSE -> OVER -> START ...
// It produces the ball freeze, the one-cycle restart pulse that clears the
// scores, and the scorer/winner status that the HUD draws.
//
// Parameters
//   WIN_SCORE     score (inclusive) that ends the match
//   PAUSE_FRAMES  frame_tick pulses the ball stays frozen after a goal
//                 that does not end the match (0 behaves as 1)
//   CNT_W         pause counter width, must be able to hold PAUSE_FRAMES
//
// Ports
//   clk_in          in   1  system clock, single domain
//   rst             in   1  synchronous active-low reset (0 = reset)
//   frame_tick      in   1  one-cycle pulse per video frame
//   start_btn       in   1  level button, only its rising edge acts
//   player_1_score  in   5  score from the ball controller
//   player_2_score  in   5  score from the ball controller
//   game_rst        out  1  active-high restart pulse, 1 cycle per (re)start
//   ball_hold       out  1  1 = ball must stay at centre
//   state           out  3  0 IDLE, 1 START, 2 PLAY, 3 PAUSE, 4 OVER
//   scorer          out  2  last goal: 0 none, 1 P1, 2 P2, 3 both
//   winner          out  2  0 none, 1 P1, 2 P2, 3 draw (meaningful in OVER)
// ---------------------------------------------------------------------------
module game_state_ctl #(
    parameter int WIN_SCORE    = 7,
    parameter int PAUSE_FRAMES = 120,
    parameter int CNT_W        = 8
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic [4:0] player_1_score,
    input  logic [4:0] player_2_score,
    output logic       game_rst,
    output logic       ball_hold,
    output logic [2:0] state,
    output logic [1:0] scorer,
    output logic [1:0] winner
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        PLAY  = 3'd2,
        PAUSE = 3'd3,
        OVER  = 3'd4
    } state_t;

    // A zero pause length would never see the count reach 1, so it is
    // treated as a single-frame pause.
    localparam int               PAUSE_LOAD_INT = (PAUSE_FRAMES < 1) ? 1 : PAUSE_FRAMES;
    localparam logic [CNT_W-1:0] PAUSE_LOAD     = CNT_W'(PAUSE_LOAD_INT);
    localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);

    state_t           state_q;
    logic             start_q;
    logic [4:0]       prev1_q;
    logic [4:0]       prev2_q;
    logic [1:0]       scorer_q;
    logic [1:0]       winner_q;
    logic [CNT_W-1:0] pause_cnt_q;

    logic             start_rise;
    logic             goal1;
    logic             goal2;
    logic             reach1;
    logic             reach2;
    logic             pause_last;
    logic [CNT_W-1:0] pause_cnt_d;

    assign start_rise = start_btn & ~start_q;

    // Only an increase counts as a goal; a drop means the ball controller
    // was reset externally and prev simply follows it.
    assign goal1  = (player_1_score > prev1_q);
    assign goal2  = (player_2_score > prev2_q);
    assign reach1 = (int'(player_1_score) >= WIN_SCORE);
    assign reach2 = (int'(player_2_score) >= WIN_SCORE);

    // <= 1 rather than == 1 so a corrupted zero count still drains out.
    assign pause_last  = (pause_cnt_q <= CNT_ONE);
    assign pause_cnt_d = pause_cnt_q - CNT_ONE;

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            prev1_q     <= 5'd0;
            prev2_q     <= 5'd0;
            scorer_q    <= 2'd0;
            winner_q    <= 2'd0;
            pause_cnt_q <= '0;
        end else begin
            start_q <= start_btn;

            case (state_q)
                IDLE: begin
                    prev1_q <= player_1_score;
                    prev2_q <= player_2_score;
                    if (start_rise) begin
                        state_q <= START;
                    end
                end

                // The ball controller clears its scores on the edge that
                // ends this cycle, so prev is forced to 0 to line up with
                // the scores it will present from the first PLAY cycle.
                START: begin
                    prev1_q  <= 5'd0;
                    prev2_q  <= 5'd0;
                    scorer_q <= 2'd0;
                    winner_q <= 2'd0;
                    state_q  <= PLAY;
                end

                PLAY: begin
                    prev1_q <= player_1_score;
                    prev2_q <= player_2_score;
                    if (goal1 || goal2) begin
                        scorer_q <= {goal2, goal1};
                        if (reach1 || reach2) begin
                            winner_q <= {reach2, reach1};
                            state_q  <= OVER;
                        end else begin
                            pause_cnt_q <= PAUSE_LOAD;
                            state_q     <= PAUSE;
                        end
                    end
                end

                PAUSE: begin
                    prev1_q <= player_1_score;
                    prev2_q <= player_2_score;
                    if (frame_tick) begin
                        pause_cnt_q <= pause_last ? '0 : pause_cnt_d;
                        if (pause_last) begin
                            state_q <= PLAY;
                        end
                    end
                end

                OVER: begin
                    prev1_q <= player_1_score;
                    prev2_q <= player_2_score;
                    if (start_rise) begin
                        state_q <= START;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign game_rst  = (state_q == START);
    assign ball_hold = (state_q != PLAY);
    assign state     = state_q;
    assign scorer    = scorer_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_game_state_ctl.sv
// ---------------------------------------------------------------------------
// tb_game_state_ctl
//
// Drives game_state_ctl through the directed match scenarios (start pulse,
// goal pause length, wins, draw, mid-match reset, ignored start presses) and
// then a long randomized run. Every cycle the DUT outputs are compared with
// a behavioural match model that tracks the match phase, the remaining pause
// frames and the last seen scores.
// ---------------------------------------------------------------------------
module tb_game_state_ctl;

    localparam int WIN   = 7;
    localparam int PAUSE = 120;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       start_btn;
    logic [4:0] player_1_score;
    logic [4:0] player_2_score;
    logic       game_rst;
    logic       ball_hold;
    logic [2:0] state;
    logic [1:0] scorer;
    logic [1:0] winner;

    int checks = 0;
    int passes = 0;

    // Model of the match: phase 0 idle, 1 start, 2 play, 3 pause, 4 over.
    int mState     = 0;
    int mScorer    = 0;
    int mWinner    = 0;
    int mPrev1     = 0;
    int mPrev2     = 0;
    int mLeft      = 0;
    bit mStartPrev = 1'b0;

    // Emulated ball-controller scores for the random phase.
    int  sc1 = 0;
    int  sc2 = 0;
    bit  curStart = 1'b0;

    game_state_ctl #(
        .WIN_SCORE   (WIN),
        .PAUSE_FRAMES(PAUSE),
        .CNT_W       (8)
    ) dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .start_btn     (start_btn),
        .player_1_score(player_1_score),
        .player_2_score(player_2_score),
        .game_rst      (game_rst),
        .ball_hold     (ball_hold),
        .state         (state),
        .scorer        (scorer),
        .winner        (winner)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic compareAll(input string where);
        checkOutput({where, ".state"},     int'(state),     mState);
        checkOutput({where, ".game_rst"},  int'(game_rst),  (mState == 1) ? 1 : 0);
        checkOutput({where, ".ball_hold"}, int'(ball_hold), (mState == 2) ? 0 : 1);
        checkOutput({where, ".scorer"},    int'(scorer),    mScorer);
        checkOutput({where, ".winner"},    int'(winner),    mWinner);
    endtask

    // Advance the match model by one clock edge with the given inputs.
    task automatic stepModel(input bit rstn, input bit st, input bit tick,
                             input int s1, input int s2);
        bit rise;
        bit g1;
        bit g2;
        if (!rstn) begin
            mState     = 0;
            mScorer    = 0;
            mWinner    = 0;
            mPrev1     = 0;
            mPrev2     = 0;
            mLeft      = 0;
            mStartPrev = 1'b0;
            return;
        end
        rise       = st && !mStartPrev;
        mStartPrev = st;
        case (mState)
            0: begin
                mPrev1 = s1;
                mPrev2 = s2;
                if (rise) mState = 1;
            end
            1: begin
                mPrev1  = 0;
                mPrev2  = 0;
                mScorer = 0;
                mWinner = 0;
                mState  = 2;
            end
            2: begin
                g1     = (s1 > mPrev1);
                g2     = (s2 > mPrev2);
                mPrev1 = s1;
                mPrev2 = s2;
                if (g1 || g2) begin
                    mScorer = (g1 ? 1 : 0) + (g2 ? 2 : 0);
                    if (s1 >= WIN || s2 >= WIN) begin
                        mWinner = ((s1 >= WIN) ? 1 : 0) + ((s2 >= WIN) ? 2 : 0);
                        mState  = 4;
                    end else begin
                        mLeft  = PAUSE;
                        mState = 3;
                    end
                end
            end
            3: begin
                mPrev1 = s1;
                mPrev2 = s2;
                if (tick) begin
                    mLeft--;
                    if (mLeft == 0) mState = 2;
                end
            end
            default: begin
                mPrev1 = s1;
                mPrev2 = s2;
                if (rise) mState = 1;
            end
        endcase
    endtask

    // Drive one cycle of inputs, step the model, then compare after the edge.
    task automatic applyStimulus(input bit rstn, input bit st, input bit tick,
                                 input int s1, input int s2);
        rst            = rstn;
        start_btn      = st;
        frame_tick     = tick;
        player_1_score = 5'(s1);
        player_2_score = 5'(s2);
        curStart       = st;
        stepModel(rstn, st, tick, s1, s2);
        @(posedge clk_in);
        @(negedge clk_in);
        compareAll("cycle");
    endtask

    initial begin
        rst            = 1'b0;
        start_btn      = 1'b0;
        frame_tick     = 1'b0;
        player_1_score = 5'd0;
        player_2_score = 5'd0;
        @(negedge clk_in);

        // Reset values
        repeat (3) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("reset.state",    int'(state),     0);
        checkOutput("reset.ballHold", int'(ball_hold), 1);
        checkOutput("reset.gameRst",  int'(game_rst),  0);

        // Start press gives one restart pulse, holding the button gives no more
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("start.pulse", int'(game_rst), 1);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("start.pulseEnd", int'(game_rst),  0);
        checkOutput("start.play",     int'(state),     2);
        checkOutput("start.ballFree", int'(ball_hold), 0);
        repeat (5) applyStimulus(1, 1, 1, 0, 0);
        checkOutput("start.noRepulse", int'(state), 2);

        // P1 goal, then exactly PAUSE ticks with start presses mixed in;
        // P2 silently moves to 6 while paused
        applyStimulus(1, 0, 0, 1, 0);
        checkOutput("goal.pause",  int'(state),  3);
        checkOutput("goal.scorer", int'(scorer), 1);
        for (int i = 0; i < PAUSE - 1; i++) begin
            applyStimulus(1, i[0], 1, 1, (i >= 60) ? 6 : 0);
            applyStimulus(1, 0, 0, 1, (i >= 60) ? 6 : 0);
        end
        checkOutput("pause.tick119", int'(state), 3);
        applyStimulus(1, 1, 1, 1, 6);
        checkOutput("pause.tick120", int'(state), 2);

        // P2 reaches the winning score
        applyStimulus(1, 0, 0, 1, 7);
        checkOutput("win.state",  int'(state),  4);
        checkOutput("win.winner", int'(winner), 2);
        applyStimulus(1, 0, 0, 1, 7);
        applyStimulus(1, 1, 0, 1, 7);
        checkOutput("restart.pulse", int'(game_rst), 1);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("restart.winnerClr", int'(winner), 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("restart.noGoal", int'(state), 2);

        // Both reach the winning score on the same cycle
        applyStimulus(1, 0, 0, 1, 0);
        repeat (PAUSE) applyStimulus(1, 0, 1, 6, 6);
        checkOutput("draw.resume", int'(state), 2);
        applyStimulus(1, 0, 0, 7, 7);
        checkOutput("draw.state",  int'(state),  4);
        checkOutput("draw.scorer", int'(scorer), 3);
        checkOutput("draw.winner", int'(winner), 3);

        // Reset in the middle of a pause with 50 frames remaining
        applyStimulus(1, 1, 0, 7, 7);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 1);
        repeat (PAUSE - 50) applyStimulus(1, 1, 1, 0, 1);
        checkOutput("abort.paused", int'(state), 3);
        applyStimulus(0, 1, 1, 0, 1);
        checkOutput("abort.idle",   int'(state),     0);
        checkOutput("abort.hold",   int'(ball_hold), 1);
        checkOutput("abort.scorer", int'(scorer),    0);
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 1);
        checkOutput("fresh.pulse", int'(game_rst), 1);

        // Randomized matches against the model
        for (int n = 0; n < 20000; n++) begin
            bit st;
            bit tick;
            bit rstn;
            int d1;
            int d2;
            st   = curStart;
            if ($urandom % 8 == 0) st = ~st;
            tick = 1'($urandom % 2);
            rstn = ($urandom % 4000 != 0);
            if (mState == 1) begin
                // Scores are ignored during the restart cycle and cleared after it
                d1  = int'($urandom % 32);
                d2  = int'($urandom % 32);
                sc1 = 0;
                sc2 = 0;
            end else begin
                if ($urandom % 24 == 0 && sc1 < 31) sc1++;
                if ($urandom % 24 == 0 && sc2 < 31) sc2++;
                if ($urandom % 300 == 0) sc1 = int'($urandom_range(0, sc1));
                if ($urandom % 300 == 0) sc2 = int'($urandom_range(0, sc2));
                d1 = sc1;
                d2 = sc2;
            end
            applyStimulus(rstn, st, tick, d1, d2);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
